// File: rtl/adbg_ahb3_pkg.sv
// Shared AHB3 encodings and the responder state type used by adbg_ahb3_slave.
package adbg_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb3_slv_state_t;

endpackage

// File: rtl/adbg_ahb3_slave_bytemask.sv
// Little-endian byte-lane enables and misalignment flag for one AHB beat.
module adbg_ahb3_slave_bytemask #(
  parameter int DATA_WIDTH = 32,
  localparam int NB        = DATA_WIDTH / 8,
  localparam int OFF_W     = $clog2(NB)
) (
  input  logic [2:0]       size,
  input  logic [OFF_W-1:0] offset,
  output logic [NB-1:0]    byte_en,
  output logic             misaligned
);

  // NOTE: every output gets a default at the top of the block so no path leaves one unassigned (no latches).
  always_comb begin
    byte_en = '0;
    for (int i = 0; i < NB; i++) begin
      byte_en[i] = (i >= int'(offset)) && (i < int'(offset) + (1 << size));
    end
    misaligned = (int'(offset) & ((1 << size) - 1)) != 0;
  end

endmodule

// File: rtl/adbg_ahb3_slave.sv
// AHB3 word-organised scratch RAM responder with programmable wait states.
// Define ADBG_AHB3_SLAVE_ERR_EN to compile in address/size/alignment ERROR responses.
module adbg_ahb3_slave
  import adbg_ahb3_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  ahb3_slv_state_t state, state_nxt;
  logic [3:0]       wait_cnt, cnt_nxt;
  logic [IDX_W-1:0] d_idx;
  logic [NB-1:0]    d_be;
  logic             d_write, d_bad;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic             accept, capture, a_err, a_bad, a_oversize, a_mis;
  logic [NB-1:0]    a_be;
  logic [IDX_W-1:0] a_idx;

  assign accept     = HSEL && HREADY && HTRANS[1];
  assign capture    = accept && (state inside {ST_IDLE, ST_DATA, ST_ERR2});
  assign a_idx      = HADDR[OFF_W +: IDX_W];
  assign a_oversize = HSIZE > 3'(OFF_W);

  adbg_ahb3_slave_bytemask #(.DATA_WIDTH(DATA_WIDTH)) u_bytemask (
    .size       (HSIZE),
    .offset     (HADDR[OFF_W-1:0]),
    .byte_en    (a_be),
    .misaligned (a_mis)
  );

`ifdef ADBG_AHB3_SLAVE_ERR_EN
  assign a_err = (|HADDR[ADDR_WIDTH-1:OFF_W+IDX_W]) || a_oversize || a_mis;
  assign a_bad = 1'b0;
  logic unused_sig;
  assign unused_sig = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
`else
  // Out-of-range indices wrap; bad size/alignment completes OKAY with no effect.
  assign a_err = 1'b0;
  assign a_bad = a_oversize || a_mis;
  logic unused_sig;
  assign unused_sig = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[ADDR_WIDTH-1:OFF_W+IDX_W]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      d_idx    <= '0;
      d_be     <= '0;
      d_write  <= 1'b0;
      d_bad    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      if (capture) begin
        d_idx   <= a_idx;
        d_be    <= a_be;
        d_write <= HWRITE;
        d_bad   <= a_bad;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (a_err) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = ST_DATA;
        else                  cnt_nxt   = wait_cnt - 4'd1;
      end
`ifdef ADBG_AHB3_SLAVE_ERR_EN
      ST_ERR1: state_nxt = ST_ERR2;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_DATA: if (!d_write && !d_bad) HRDATA = mem[d_idx];
`ifdef ADBG_AHB3_SLAVE_ERR_EN
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
`endif
      default: ;
    endcase
  end

  // NOTE: the storage array has no reset; contents survive HRESETn and only control state clears.
  always_ff @(posedge HCLK) begin
    if (state == ST_DATA && d_write && !d_bad) begin
      for (int i = 0; i < NB; i++) begin
        if (d_be[i]) mem[d_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_adbg_ahb3_slave.sv
// Self-checking bench: two responders (0 and 3 wait states) against a transaction-level model.
module tb_adbg_ahb3_slave;
  import adbg_ahb3_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int NB    = DW / 8;

  typedef struct {
    bit            sel;
    logic [1:0]    trans;
    bit            write;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    bit            rdy;
    bit            resp;
    logic [DW-1:0] rdata;
    bit            lit_en;
    logic [DW-1:0] lit;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic op_t mk(bit sel, logic [1:0] trans, bit wr, logic [AW-1:0] a,
                             logic [2:0] sz, logic [DW-1:0] d);
    op_t o;
    o.sel = sel; o.trans = trans; o.write = wr; o.addr = a; o.size = sz; o.data = d;
    return o;
  endfunction

  function automatic exp_t mk_exp(bit rdy, bit resp, logic [DW-1:0] rd);
    exp_t e;
    e.rdy = rdy; e.resp = resp; e.rdata = rd; e.lit_en = 1'b0; e.lit = '0;
    return e;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.sel   = ($urandom_range(0, 9) != 0);
    o.trans = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0) o.trans[1] = 1'b1;
    o.write = 1'($urandom_range(0, 1));
    o.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    o.addr  = AW'($urandom_range(0, (DEPTH + 4) * NB - 1));
    if ($urandom_range(0, 3) != 0 && o.size < 3) o.addr &= ~(AW'((1 << o.size) - 1));
    o.data  = DW'($urandom);
    return o;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int WS = (g == 0) ? 0 : 3;

    logic          rst_n;
    logic          h_sel, h_write, h_lock, h_ready;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata, h_rdata;
    logic [2:0]    h_size, h_burst;
    logic [3:0]    h_prot;
    logic [1:0]    h_trans;
    logic          h_readyout, h_resp;

    adbg_ahb3_slave #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS)
    ) dut (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(h_sel), .HADDR(h_addr), .HWDATA(h_wdata),
      .HWRITE(h_write), .HSIZE(h_size), .HBURST(h_burst), .HPROT(h_prot),
      .HTRANS(h_trans), .HMASTLOCK(h_lock), .HREADY(h_ready),
      .HREADYOUT(h_readyout), .HRESP(h_resp), .HRDATA(h_rdata)
    );

    logic [DW-1:0] mem_m [DEPTH];
    exp_t          prev_list[$];
    logic [DW-1:0] prev_wdata;
    bit            prev_wr = 1'b0;
    exp_t          exp_cur;
    bit            exp_valid = 1'b0;
    bit            done = 1'b0;

    always @(negedge clk) begin
      if (exp_valid) begin
        check($sformatf("ws%0d hreadyout", WS), 64'(h_readyout), 64'(exp_cur.rdy));
        check($sformatf("ws%0d hresp", WS), 64'(h_resp), 64'(exp_cur.resp));
        check($sformatf("ws%0d hrdata", WS), 64'(h_rdata), 64'(exp_cur.rdata));
        if (exp_cur.lit_en)
          check($sformatf("ws%0d hrdata_literal", WS), 64'(h_rdata), 64'(exp_cur.lit));
      end
    end

    task automatic drive_addr(input op_t op);
      h_sel   = op.sel;
      h_trans = op.trans;
      h_write = op.write;
      h_addr  = op.addr;
      h_size  = op.size;
      h_burst = 3'($urandom);
      h_prot  = 4'($urandom);
      h_lock  = 1'($urandom);
    endtask

    // Address signals while HREADY is low are noise the responder must ignore.
    task automatic drive_junk();
      op_t j;
      j = rand_op();
      j.sel = 1'b1;
      j.trans = HTRANS_NONSEQ;
      drive_addr(j);
    endtask

    // Play out the previous beat's data phase while offering op's address phase.
    task automatic present(input op_t op);
      for (int c = 0; c < prev_list.size(); c++) begin
        if (c == prev_list.size() - 1) drive_addr(op);
        else drive_junk();
        h_wdata   = prev_wr ? prev_wdata : DW'($urandom);
        h_ready   = prev_list[c].rdy;
        exp_cur   = prev_list[c];
        exp_valid = 1'b1;
        @(posedge clk); #1;
      end
    endtask

    task automatic model_op(input op_t op, input bit commit);
      int unsigned idx, off, bytes;
      bit ovs, mis, bad;
      prev_list.delete();
      prev_wr    = 1'b0;
      prev_wdata = op.data;
      if (!(op.sel && op.trans[1])) begin
        prev_list.push_back(mk_exp(1'b1, 1'b0, '0));
        return;
      end
      idx   = op.addr / NB;
      off   = op.addr % NB;
      bytes = 1 << op.size;
      ovs   = bytes > NB;
      mis   = (op.addr % bytes) != 0;
`ifdef ADBG_AHB3_SLAVE_ERR_EN
      if (idx >= DEPTH || ovs || mis) begin
        prev_list.push_back(mk_exp(1'b0, 1'b1, '0));
        prev_list.push_back(mk_exp(1'b1, 1'b1, '0));
        return;
      end
      bad = 1'b0;
`else
      idx = idx % DEPTH;
      bad = ovs || mis;
`endif
      repeat (WS) prev_list.push_back(mk_exp(1'b0, 1'b0, '0));
      if (op.write) begin
        prev_wr = 1'b1;
        if (!bad && commit)
          for (int b = 0; b < bytes; b++)
            mem_m[idx][8*(off+b) +: 8] = op.data[8*(off+b) +: 8];
        prev_list.push_back(mk_exp(1'b1, 1'b0, '0));
      end else begin
        prev_list.push_back(mk_exp(1'b1, 1'b0, bad ? '0 : mem_m[idx]));
      end
    endtask

    task automatic run(input op_t op);
      present(op);
      model_op(op, 1'b1);
    endtask

    task automatic pin(input logic [DW-1:0] v);
      exp_t e;
      e = prev_list[prev_list.size() - 1];
      e.lit_en = 1'b1;
      e.lit    = v;
      prev_list[prev_list.size() - 1] = e;
    endtask

    task automatic go_idle_exp();
      h_sel = 1'b0; h_trans = HTRANS_IDLE; h_ready = 1'b1;
      exp_cur = mk_exp(1'b1, 1'b0, '0);
      exp_valid = 1'b1;
    endtask

    // Write whose data phase is cut by reset during its wait states; the write must vanish.
    task automatic reset_in_wait(input logic [AW-1:0] a, input logic [DW-1:0] d);
      op_t op;
      op = mk(1'b1, HTRANS_NONSEQ, 1'b1, a, HSIZE_WORD, d);
      present(op);
      model_op(op, 1'b0);
      drive_junk();
      h_wdata = d; h_ready = 1'b0; exp_cur = prev_list[0];
      @(posedge clk); #1;
      rst_n = 1'b0;
      go_idle_exp();
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      prev_list.delete();
      prev_list.push_back(mk_exp(1'b1, 1'b0, '0));
      prev_wr = 1'b0;
    endtask

    initial begin
      rst_n = 1'b0;
      h_wdata = '0; h_addr = '0; h_write = 1'b0; h_size = '0;
      h_burst = '0; h_prot = '0; h_lock = 1'b0;
      go_idle_exp();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      prev_list.push_back(mk_exp(1'b1, 1'b0, '0));

      run(mk(1, HTRANS_NONSEQ, 1, 'h10, HSIZE_WORD, 'hDEADBEEF));
      run(mk(1, HTRANS_NONSEQ, 0, 'h10, HSIZE_WORD, DW'($urandom)));
      pin('hDEADBEEF);
      run(mk(1, HTRANS_NONSEQ, 1, 'h10, HSIZE_WORD, 'h11223344));
      run(mk(1, HTRANS_NONSEQ, 1, 'h13, HSIZE_BYTE, {8'hAA, 24'($urandom)}));
      run(mk(1, HTRANS_NONSEQ, 0, 'h10, HSIZE_WORD, '0));
      pin('hAA223344);

      for (int i = 0; i < DEPTH; i++)
        if (i != 4) run(mk(1, (i % 2) ? HTRANS_SEQ : HTRANS_NONSEQ, 1, AW'(i * NB), HSIZE_WORD, DW'($urandom)));
      run(mk(1, HTRANS_NONSEQ, 0, 'h00, HSIZE_WORD, '0));
      run(mk(1, HTRANS_SEQ, 0, 'h04, HSIZE_WORD, '0));

`ifdef ADBG_AHB3_SLAVE_ERR_EN
      run(mk(1, HTRANS_NONSEQ, 0, 'h01, HSIZE_HALF, '0));
      run(mk(1, HTRANS_NONSEQ, 0, AW'(DEPTH * NB), HSIZE_WORD, '0));
      run(mk(1, HTRANS_IDLE, 0, '0, HSIZE_WORD, '0));
      run(mk(1, HTRANS_NONSEQ, 1, AW'(DEPTH * NB), HSIZE_WORD, DW'($urandom)));
      run(mk(1, HTRANS_NONSEQ, 1, 'h12, HSIZE_WORD, DW'($urandom)));
      run(mk(1, HTRANS_NONSEQ, 0, 'h10, HSIZE_DWORD, '0));
      run(mk(1, HTRANS_NONSEQ, 0, 'h10, HSIZE_WORD, '0));
      pin('hAA223344);
`else
      run(mk(1, HTRANS_NONSEQ, 1, AW'((DEPTH + 2) * NB), HSIZE_WORD, 'h5));
      run(mk(1, HTRANS_NONSEQ, 0, 'h08, HSIZE_WORD, '0));
      pin('h5);
      run(mk(1, HTRANS_NONSEQ, 1, 'h09, HSIZE_HALF, 'hFFFF_FFFF));
      run(mk(1, HTRANS_NONSEQ, 0, 'h08, HSIZE_WORD, '0));
      pin('h5);
      run(mk(1, HTRANS_NONSEQ, 0, 'h0B, HSIZE_HALF, '0));
      pin('h0);
      run(mk(1, HTRANS_NONSEQ, 0, 'h08, HSIZE_DWORD, '0));
`endif

      run(mk(1, HTRANS_IDLE, 1, 'h10, HSIZE_WORD, 'h0BAD0BAD));
      run(mk(1, HTRANS_BUSY, 1, 'h10, HSIZE_WORD, 'h0BAD0BAD));
      run(mk(0, HTRANS_NONSEQ, 1, 'h10, HSIZE_WORD, 'h0BAD0BAD));
      run(mk(1, HTRANS_NONSEQ, 0, 'h10, HSIZE_WORD, '0));
      pin('hAA223344);

      if (WS > 0) begin
        reset_in_wait('h10, 'h12345678);
        run(mk(1, HTRANS_NONSEQ, 0, 'h10, HSIZE_WORD, '0));
        pin('hAA223344);
      end

      repeat (300) run(rand_op());
      run(mk(0, HTRANS_IDLE, 0, '0, HSIZE_WORD, '0));
      run(mk(0, HTRANS_IDLE, 0, '0, HSIZE_WORD, '0));
      exp_valid = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(lane[0].done && lane[1].done) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    check("completion_before_timeout", 64'(lane[0].done && lane[1].done), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adbg_ahb3_slave.md
# adbg_ahb3_slave

AHB3 responder that terminates the debug bus master's transfers: a word-organised register-file memory with programmable wait states and a two-cycle ERROR response. It sits on the `dbg_H*` side of the debug interface, as the bench target for the AHB debug module and as a small scratch/mailbox RAM in SoC integrations.

## Interface
- `ADDR_WIDTH`, 32: HADDR width.
- `DATA_WIDTH`, 32: HWDATA/HRDATA width; 32 or 64.
- `MEM_DEPTH`, 256: number of `DATA_WIDTH` words; power of two.
- `WAIT_STATES`, 0: HREADYOUT-low cycles inserted in every OKAY data phase; 0..15.

Ports:
- `HCLK`  in  1  bus clock.
- `HRESETn`  in  1  reset; asynchronous, active-low.
- `HSEL`  in  1  slave select.
- `HADDR`  in  ADDR_WIDTH  byte address.
- `HWDATA`  in  DATA_WIDTH  write data, data phase.
- `HWRITE`  in  1  1 = write.
- `HSIZE`  in  3  transfer size.
- `HBURST`  in  3  ignored; every beat is decoded individually.
- `HPROT`  in  4  ignored.
- `HTRANS`  in  2  IDLE/BUSY/NONSEQ/SEQ.
- `HMASTLOCK`  in  1  ignored.
- `HREADY`  in  1  bus-wide ready.
- `HREADYOUT`  out  1  slave ready.
- `HRESP`  out  1  0 = OKAY, 1 = ERROR.
- `HRDATA`  out  DATA_WIDTH  read data.

## Operation
- Address phase accepted when `HSEL && HREADY && HTRANS[1]`. On acceptance, register word index, byte offset, HSIZE and HWRITE, and compute the error flag.
- IDLE/BUSY, or no HSEL, while HREADY is high: no data phase follows; next cycle is zero-wait OKAY.
- Error conditions:
  - word index ≥ MEM_DEPTH (upper address bits non-zero);
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR not aligned to HSIZE.
- State machine:
  - ST_IDLE (HREADYOUT=1, HRESP=0): accepted OKAY transfer → ST_WAIT if WAIT_STATES>0, else ST_DATA. Accepted error transfer → ST_ERR1.
  - ST_WAIT (HREADYOUT=0, HRESP=0): 4-bit counter loaded with WAIT_STATES-1, decremented each cycle; at 0 → ST_DATA.
  - ST_DATA (HREADYOUT=1, HRESP=0): transfer completes. New address phase is accepted in the same cycle (pipelined) and dispatched as in ST_IDLE; otherwise → ST_IDLE.
  - ST_ERR1 (HREADYOUT=0, HRESP=1) → ST_ERR2.
  - ST_ERR2 (HREADYOUT=1, HRESP=1): address phase sampled here is handled as in ST_IDLE. A transfer the master cancels to IDLE is not accepted.
- Write: memory updated at the ST_DATA clock edge. Only byte lanes selected by HSIZE/offset are written (little-endian). Erroring writes modify nothing.
- Read: HRDATA = memory word at the registered index, valid whenever HREADYOUT=1 in a read data phase. HRDATA = 0 in all other cycles.
- A read directly following a write to the same word returns the new data.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state ST_IDLE, counter 0. Memory contents are not reset.
- OKAY latency: data phase lasts WAIT_STATES+1 cycles after address acceptance.
- ERROR response is always exactly two cycles, independent of WAIT_STATES.
- Reset asserted mid-transfer: outputs return to reset values immediately (asynchronously). Any pending write is discarded.

## Configuration
- `ADBG_AHB3_SLAVE_ERR_EN` defined: error detection and the ST_ERR1/ST_ERR2 path are compiled in as above.
- Not defined:
  - HRESP is tied to 0 and the error states are absent;
  - out-of-range indices wrap modulo MEM_DEPTH;
  - oversize or misaligned accesses complete OKAY, with writes suppressed and reads returning 0.

## Structure
- Shared package `adbg_ahb3_pkg` holds the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), the HSIZE encodings, the HRESP OKAY/ERROR constants, and the state enum `ahb3_slv_state_t`.
- One sub-module: `adbg_ahb3_slave_bytemask`, a combinational function of HSIZE and offset that produces the byte-enable vector and the misalignment flag.

## Test plan
- Reset, WAIT_STATES=0: 32-bit write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → each data phase one cycle, OKAY, HRDATA=0xDEADBEEF.
- Byte write 0xAA to 0x13 over word 0x11223344 → read 0x10 returns 0xAA223344.
- WAIT_STATES=3: pipelined NONSEQ read then SEQ read → HREADYOUT low for exactly 3 cycles per beat; second address accepted in the first beat's completion cycle.
- With ERR_EN: halfword read at 0x01, then access to word index MEM_DEPTH → each gives HREADYOUT 0 then 1 with HRESP=1 for both cycles, and memory is unchanged.
- IDLE/BUSY with HSEL=1 → HREADYOUT=1, HRESP=0, no memory change. Assert HRESETn low during ST_WAIT → outputs at reset values the same cycle, and the write is lost.
- Without ERR_EN: write 0x5 at index MEM_DEPTH+2, then read index 2 → 0x5, OKAY.
